counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Control FSM and owned WIDTH-bit up-counter providing start/stop/pause, periodic or one-shot
//  modes, and terminal-count signalling. Sits between the control/register logic and
//  downstream consumers of count value, tc_pulse and done. One instance per timer channel.
// PARAMETERS
//  WIDTH       4  counter and limit width in bits
//  PRESCALE_W  4  prescale field width (used only with COUNTER_PRESCALE_EN)
// PORTS
//  clk           in   1           clock; all state updates on posedge
//  rst           in   1           asynchronous, active-low reset (0 = reset)
//  start         in   1           level sampled at posedge; honoured only in IDLE or DONE
//  stop          in   1           abort to IDLE; highest priority after rst
//  pause         in   1           level; holds counter while high (RUN<->HOLD)
//  cfg_periodic  in   1           1 = wrap and continue at limit, 0 = one-shot
//  cfg_limit     in   WIDTH       terminal value; latched into limit_q on accepted start
//  cfg_prescale  in   PRESCALE_W  tick divider, present only with COUNTER_PRESCALE_EN
//  count         out  WIDTH       registered counter value
//  busy          out  1           1 in RUN or HOLD
//  done          out  1           1 in DONE (one-shot finished)
//  tc_pulse      out  1           registered one-cycle pulse per terminal count
// BEHAVIOUR
//  - rst=0 (async): state=IDLE, count=0, limit_q=0, busy=0, done=0, tc_pulse=0, prescale cnt=0.
//  - States IDLE, RUN, HOLD, DONE (2-bit encoding). busy/done decoded from registered state.
//  - Priority per edge: stop > start > pause > tick.
//  - IDLE: start=1 -> RUN, count<=0, limit_q<=cfg_limit. Otherwise hold, count stays 0.
//  - RUN: pause=1 -> HOLD (no increment that edge). Else on tick:
//      count!=limit_q -> count<=count+1;
//      count==limit_q & cfg_periodic -> count<=0, tc_pulse<=1, stay RUN;
//      count==limit_q & !cfg_periodic -> DONE, count holds limit_q, tc_pulse<=1.
//  - HOLD: count and prescale frozen; pause=0 -> RUN, counting resumes on next tick.
//  - DONE: count holds limit_q; start=1 -> RUN with count<=0 and new limit_q latched.
//  - stop=1 from any state -> IDLE, count<=0, tc_pulse<=0; stop+start same edge -> IDLE.
//  - start in RUN/HOLD is ignored (no restart; limit_q unchanged).
//  - tc_pulse is 0 on every edge that does not set it; never high two consecutive cycles
//    unless limit_q=0 in periodic mode with a tick every cycle.
//  - Latency: start accepted at edge N -> busy=1 after N; first increment at first tick
//    after N (edge N+1 without prescale). Period = limit_q+1 ticks.
//  - limit_q=0: periodic -> tc_pulse every tick, count stays 0; one-shot -> DONE at first tick.
//  - cfg_periodic is read live each terminal event; change mid-run takes effect at next TC.
//  - Counter arithmetic modulo 2^WIDTH; count never exceeds limit_q.
// CONFIGURATION
//  COUNTER_PRESCALE_EN defined: cfg_prescale port present; internal PRESCALE_W-bit divider;
//    tick asserted once every cfg_prescale+1 clocks in RUN; divider cleared on accepted start,
//    on stop and in IDLE/DONE; frozen in HOLD; cfg_prescale=0 gives tick every clock.
//  COUNTER_PRESCALE_EN undefined: no cfg_prescale port, no divider; tick=1 every RUN clock.
// TESTING
//  1 rst=0 mid-RUN (count=2), async, no clock edge -> count=0, busy=0, done=0, tc_pulse=0 at once.
//  2 limit=3, periodic, start 1 cycle -> count 0,1,2,3,0,1..; tc_pulse high 1 cycle every 4 clocks.
//  3 limit=5, one-shot -> count reaches 5, tc_pulse once, done=1, busy=0, count holds 5; start -> 0.
//  4 limit=9, pause high 3 cycles at count=4 -> count stays 4 throughout, resumes 5 after release.
//  5 start and stop same edge from IDLE, then stop at count=7 in RUN -> IDLE, count=0, no tc_pulse.
//  6 limit=0 periodic -> tc_pulse continuous; with COUNTER_PRESCALE_EN, prescale=2, limit=1 ->
//    count changes every 3 clocks, tc_pulse every 6 clocks.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Start/stop/pause controller around an owned WIDTH-bit up-counter with
//   periodic or one-shot terminal-count behaviour. One instance per timer
//   channel.
//   Optional feature macro: COUNTER_PRESCALE_EN adds the i_cfg_prescale port
//   and an internal tick divider; without it every RUN clock is a tick.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | stopped, count held at 0, waiting for start
//   S_RUN  | counting on each tick toward limit_q
//   S_HOLD | paused, count and prescale divider frozen
//   S_DONE | one-shot finished, count holds limit_q until next start
module counter_sequencer #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_pause,
  input  logic                  i_cfg_periodic,
  input  logic [WIDTH-1:0]      i_cfg_limit,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] i_cfg_prescale,
`endif
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_tc_pulse
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] w_limit_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             w_tick;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_pre;
  logic [PRESCALE_W-1:0] w_pre_nxt;

  assign w_tick = (r_pre == i_cfg_prescale);

  // Divider advances only while counting; frozen on the pause edge and in HOLD,
  // cleared on stop and whenever the FSM sits in IDLE or DONE.
  always_comb begin
    w_pre_nxt = '0;
    if (!i_stop) begin
      if (r_state == S_HOLD) begin
        w_pre_nxt = r_pre;
      end else if (r_state == S_RUN) begin
        if (i_pause) begin
          w_pre_nxt = r_pre;
        end else if (w_tick) begin
          w_pre_nxt = '0;
        end else begin
          w_pre_nxt = r_pre + PRESCALE_W'(1);
        end
      end
    end
  end

  // Prescale divider register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_pre_nxt;
    end
  end
`else
  // No divider: every RUN clock is a tick (constant true for any legal width).
  assign w_tick = (PRESCALE_W > 0);
`endif

  // Next-state, counter and terminal-count decode; priority stop > start > pause > tick.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_limit_nxt = r_limit;
    w_tc_nxt    = 1'b0;
    if (i_stop) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_count_nxt = '0;
          if (i_start) begin
            w_state_nxt = S_RUN;
            w_limit_nxt = i_cfg_limit;
          end
        end
        S_RUN: begin
          if (i_pause) begin
            w_state_nxt = S_HOLD;
          end else if (w_tick) begin
            if (r_count != r_limit) begin
              w_count_nxt = r_count + WIDTH'(1);
            end else if (i_cfg_periodic) begin
              w_count_nxt = '0;
              w_tc_nxt    = 1'b1;
            end else begin
              w_state_nxt = S_DONE;
              w_tc_nxt    = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!i_pause) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          if (i_start) begin
            w_state_nxt = S_RUN;
            w_count_nxt = '0;
            w_limit_nxt = i_cfg_limit;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // State, counter, latched limit and terminal-count pulse registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_limit <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_limit <= w_limit_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign o_count    = r_count;
  assign o_busy     = (r_state == S_RUN) || (r_state == S_HOLD);
  assign o_done     = (r_state == S_DONE);
  assign o_tc_pulse = r_tc;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed stimulus pushes hand-computed
// expectations tagged with the clock edge they apply to; a monitor pops and
// compares them on the following falling edge (or immediately for async reset).
module tb_counter_sequencer;
  localparam int WIDTH = 4;
  localparam int PW    = 4;

  typedef struct {
    int    cyc;
    int    count;
    logic  busy;
    logic  done;
    logic  tc;
    string name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             pause;
  logic             cfg_periodic;
  logic [WIDTH-1:0] cfg_limit;
`ifdef COUNTER_PRESCALE_EN
  logic [PW-1:0]    cfg_prescale;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc_pulse;

  exp_t q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  event ev_now;

  counter_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
`ifdef COUNTER_PRESCALE_EN
    .i_cfg_prescale (cfg_prescale),
`endif
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_stop         (stop),
    .i_pause        (pause),
    .i_cfg_periodic (cfg_periodic),
    .i_cfg_limit    (cfg_limit),
    .o_count        (count),
    .o_busy         (busy),
    .o_done         (done),
    .o_tc_pulse     (tc_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  // Monitor: compare every expectation due at this edge (tag -1 = check now).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or ev_now);
      while (q.size() > 0 && q[0].cyc >= 0 && q[0].cyc < edge_cnt) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d never compared (now %0d)", e.name, e.cyc, edge_cnt);
      end
      while (q.size() > 0 && (q[0].cyc == edge_cnt || q[0].cyc < 0)) begin
        e = q.pop_front();
        checks++;
        if (count != WIDTH'(e.count) || busy !== e.busy || done !== e.done || tc_pulse !== e.tc) begin
          errors++;
          $display("FAIL %s @%0t: got count=%0d busy=%0b done=%0b tc=%0b, want count=%0d busy=%0b done=%0b tc=%0b",
                   e.name, $time, count, busy, done, tc_pulse, e.count, e.busy, e.done, e.tc);
        end
      end
    end
  end

  // Drive inputs for the next edge and optionally expect the outputs after it.
  task automatic step(input string nm, input logic st, input logic sp, input logic pa,
                      input bit chk, input int c, input logic b, input logic d, input logic t);
    exp_t e;
    start = st;
    stop  = sp;
    pause = pa;
    if (chk) begin
      e.cyc = edge_cnt + 1; e.count = c; e.busy = b; e.done = d; e.tc = t; e.name = nm;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    exp_t e;
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    cfg_periodic = 1'b0; cfg_limit = '0;
`ifdef COUNTER_PRESCALE_EN
    cfg_prescale = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    step("reset_idle", 0, 0, 0, 1, 0, 0, 0, 0);

    // Periodic, limit 3: 0,1,2,3,0,... with tc on each wrap.
    cfg_limit = 4'd3; cfg_periodic = 1'b1;
    step("per_start", 1, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) step("per_count", 0, 0, 0, 1, k % 4, 1, 0, (k % 4) == 0);
    step("per_stop", 0, 1, 0, 1, 0, 0, 0, 0);

    // One-shot, limit 5, then restart with new limit 2 while start held in RUN.
    cfg_limit = 4'd5; cfg_periodic = 1'b0;
    step("os_start", 1, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) step("os_count", 0, 0, 0, 1, k, 1, 0, 0);
    step("os_tc", 0, 0, 0, 1, 5, 0, 1, 1);
    step("os_hold1", 0, 0, 0, 1, 5, 0, 1, 0);
    step("os_hold2", 0, 0, 0, 1, 5, 0, 1, 0);
    cfg_limit = 4'd2;
    step("os_restart", 1, 0, 0, 1, 0, 1, 0, 0);
    cfg_limit = 4'd7;
    step("os_start_in_run", 1, 0, 0, 1, 1, 1, 0, 0);
    step("os_count2", 0, 0, 0, 1, 2, 1, 0, 0);
    step("os_tc2", 0, 0, 0, 1, 2, 0, 1, 1);
    step("os_stop", 0, 1, 0, 1, 0, 0, 0, 0);

    // Pause at count 4 for three cycles, limit 9.
    cfg_limit = 4'd9; cfg_periodic = 1'b1;
    step("pz_start", 1, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) step("pz_count", 0, 0, 0, 1, k, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("pz_hold", 0, 0, 1, 1, 4, 1, 0, 0);
    step("pz_release", 0, 0, 0, 1, 4, 1, 0, 0);
    step("pz_resume5", 0, 0, 0, 1, 5, 1, 0, 0);
    step("pz_resume6", 0, 0, 0, 1, 6, 1, 0, 0);
    step("pz_stop", 0, 1, 0, 1, 0, 0, 0, 0);

    // start+stop same edge stays IDLE; stop at count 7.
    step("ss_same_edge", 1, 1, 0, 1, 0, 0, 0, 0);
    step("ss_idle", 0, 0, 0, 1, 0, 0, 0, 0);
    step("ss_start", 1, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 7; k++) step("ss_count", 0, 0, 0, 1, k, 1, 0, 0);
    step("ss_stop7", 0, 1, 0, 1, 0, 0, 0, 0);
    step("ss_idle2", 0, 0, 0, 1, 0, 0, 0, 0);

    // Async reset mid-RUN at count 2, checked before any further clock edge.
    step("ar_start", 1, 0, 0, 1, 0, 1, 0, 0);
    step("ar_c1", 0, 0, 0, 1, 1, 1, 0, 0);
    step("ar_c2", 0, 0, 0, 1, 2, 1, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    e.cyc = -1; e.count = 0; e.busy = 1'b0; e.done = 1'b0; e.tc = 1'b0; e.name = "async_reset";
    q.push_back(e);
    ->ev_now;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step("ar_after", 0, 0, 0, 1, 0, 0, 0, 0);

    // limit 0 periodic: tc every cycle; switch to one-shot live -> DONE at next TC.
    cfg_limit = 4'd0; cfg_periodic = 1'b1;
    step("z_start", 1, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) step("z_tc", 0, 0, 0, 1, 0, 1, 0, 1);
    cfg_periodic = 1'b0;
    step("z_oneshot", 0, 0, 0, 1, 0, 0, 1, 1);
    step("z_done", 0, 0, 0, 1, 0, 0, 1, 0);
    step("z_stop", 0, 1, 0, 1, 0, 0, 0, 0);

`ifdef COUNTER_PRESCALE_EN
    // Prescale 2, limit 1: count changes every 3 clocks, tc every 6.
    cfg_prescale = 4'd2; cfg_limit = 4'd1; cfg_periodic = 1'b1;
    step("ps_start", 1, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) step("ps_count", 0, 0, 0, 1, (k / 3) % 2, 1, 0, (k % 6) == 0);
    step("ps_stop", 0, 1, 0, 1, 0, 0, 0, 0);
    cfg_prescale = '0;
`endif

    step("final_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
